// File: rtl/timer_pkg.sv
// Shared definitions for the countdown controller: controller state encoding
// and the default prescaler division.
package timer_pkg;

   localparam int DEF_TICK_DIV = 50_000_000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_PAUSED = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 prescaler with hold and clear; o_tick is a
// registered flag that is high exactly while the count sits at TICK_DIV-1.
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;
   logic             r_tick;

   always_comb begin
      w_cntNext = r_cnt;
      if (i_clr) begin
         w_cntNext = '0;
      end else if (i_en) begin
         w_cntNext = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   // The tick follows the next count so it stays valid across a hold.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_cntNext;
         r_tick <= (w_cntNext == LAST);
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/countdown_ctrl.sv
// Initiator of the digit borrow chain: periodic borrow requests, reload pulses
// and timeout detection. Define AUTO_RELOAD_EN to restart automatically after DONE.
module countdown_ctrl
   import timer_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   input  logic i_pause,
   input  logic i_reload,
   input  logic i_chain_empty,
   output logic o_reconfig,
   output logic o_borrow_req,
   output logic o_running,
   output logic o_timeout,
   output logic o_timeout_pulse
);

   state_t r_state;
   state_t w_stateNext;
   logic   w_tick;
   logic   w_cntEn;
   logic   w_cntClr;
   logic   w_borrowNext;
   logic   r_reconfig;
   logic   r_borrowReq;
   logic   r_running;
   logic   r_timeout;
   logic   r_timeoutPulse;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (w_cntEn),
      .i_clr  (w_cntClr),
      .o_tick (w_tick)
   );

   // Counting only happens in cycles that stay in RUN, so timeout, pause and
   // reload all suppress the tick and leave the prescaler untouched or cleared.
   always_comb begin
      w_stateNext  = r_state;
      w_cntEn      = 1'b0;
      w_borrowNext = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_reload)     w_stateNext = ST_LOAD;
            else if (i_start) w_stateNext = ST_RUN;
         end
         ST_LOAD: begin
            w_stateNext = ST_SETTLE;
         end
         ST_SETTLE: begin
`ifdef AUTO_RELOAD_EN
            w_stateNext = ST_RUN;
`else
            w_stateNext = ST_IDLE;
`endif
         end
         ST_RUN: begin
            if (i_reload)            w_stateNext = ST_LOAD;
            else if (i_chain_empty)  w_stateNext = ST_DONE;
            else if (i_pause)        w_stateNext = ST_PAUSED;
            else begin
               w_cntEn      = 1'b1;
               w_borrowNext = w_tick;
            end
         end
         ST_PAUSED: begin
            if (i_reload)     w_stateNext = ST_LOAD;
            else if (i_start) w_stateNext = ST_RUN;
         end
         ST_DONE: begin
`ifdef AUTO_RELOAD_EN
            w_stateNext = ST_LOAD;
`else
            if (i_reload) w_stateNext = ST_LOAD;
`endif
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
      w_cntClr = (w_stateNext == ST_LOAD);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state        <= ST_IDLE;
         r_reconfig     <= 1'b0;
         r_borrowReq    <= 1'b0;
         r_running      <= 1'b0;
         r_timeout      <= 1'b0;
         r_timeoutPulse <= 1'b0;
      end else begin
         r_state        <= w_stateNext;
         r_reconfig     <= (w_stateNext == ST_LOAD);
         r_borrowReq    <= w_borrowNext;
         r_running      <= (w_stateNext == ST_RUN);
         r_timeout      <= (w_stateNext == ST_DONE);
         r_timeoutPulse <= (w_stateNext == ST_DONE) && (r_state != ST_DONE);
      end
   end

   assign o_reconfig      = r_reconfig;
   assign o_borrow_req    = r_borrowReq;
   assign o_running       = r_running;
   assign o_timeout       = r_timeout;
   assign o_timeout_pulse = r_timeoutPulse;

endmodule
